// File: rtl/multiexp_dispatch.sv
// Front-end scheduler for a bank of multiexp_fp2_core instances: round-robin packet dispatch,
// per-core point counts, and a final reduction of the per-core results through core 0.
module multiexp_dispatch #(
    parameter int NUM_CORES = 4,
    parameter int DAT_BITS  = 381,
    parameter int CTL_BITS  = 16,
    parameter int NUM_WRDS  = 6,
    parameter int KEY_BITS  = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [63:0]                   i_num_in,
    output logic                          o_busy,
    input  logic [DAT_BITS-1:0]           i_dat,
    input  logic                          i_val,
    input  logic                          i_sop,
    input  logic                          i_eop,
    output logic                          o_rdy,
    output logic [NUM_CORES*DAT_BITS-1:0] o_core_dat,
    output logic [NUM_CORES-1:0]          o_core_val,
    output logic [NUM_CORES-1:0]          o_core_sop,
    output logic [NUM_CORES-1:0]          o_core_eop,
    output logic [NUM_CORES*CTL_BITS-1:0] o_core_ctl,
    input  logic [NUM_CORES-1:0]          i_core_rdy,
    output logic [NUM_CORES*64-1:0]       o_core_num_in,
    input  logic [NUM_CORES*DAT_BITS-1:0] i_res_dat,
    input  logic [NUM_CORES-1:0]          i_res_val,
    input  logic [NUM_CORES-1:0]          i_res_sop,
    input  logic [NUM_CORES-1:0]          i_res_eop,
    output logic [NUM_CORES-1:0]          o_res_rdy,
    output logic [DAT_BITS-1:0]           o_pnt_dat,
    output logic                          o_pnt_val,
    output logic                          o_pnt_sop,
    output logic                          o_pnt_eop,
    input  logic                          i_pnt_rdy
);

    localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int K_W   = $clog2(NUM_CORES + 1);
    localparam int LOG2C = $clog2(NUM_CORES);
    localparam int CNT_W = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        DRAIN0,
        FWD,
        WAIT,
        OUT_PASS,
        OUT_ZERO
    } state_t;

    state_t                  state_q, state_d;
    logic [63:0]             num_q, num_d;
    logic [63:0]             pkt_idx_q, pkt_idx_d;
    logic [63:0]             pass_q, pass_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [SEL_W-1:0]        k_q, k_d;
    logic [K_W-1:0]          a_q, a_d;
    logic [CNT_W-1:0]        wrd_q, wrd_d;
    logic [NUM_CORES*64-1:0] core_num_q, core_num_d;

    logic [63:0]             numMod;
    logic [NUM_CORES*64-1:0] startCnt;
    logic [DAT_BITS-1:0]     resDatK;
    logic                    resValK, resSopK, resEopK;
    logic                    kLast, passThru;
    logic                    chkVld, chkSop, chkEop;

    assign resDatK       = i_res_dat[k_q*DAT_BITS +: DAT_BITS];
    assign resValK       = i_res_val[k_q];
    assign resSopK       = i_res_sop[k_q];
    assign resEopK       = i_res_eop[k_q];
    assign kLast         = (K_W'(k_q) == a_q - K_W'(1));
    assign passThru      = (state_q == OUT_PASS) || ((state_q == WAIT) && kLast);
    assign o_busy        = (state_q != IDLE);
    assign o_core_num_in = core_num_q;

    // Per-core point counts for a new job: base share plus one for the first N%NUM_CORES cores.
    always_comb begin
        startCnt = '0;
        numMod   = i_num_in & 64'(NUM_CORES - 1);
        for (int c = 0; c < NUM_CORES; c++) begin
            startCnt[c*64 +: 64] = (i_num_in >> LOG2C) + ((64'(c) < numMod) ? 64'd1 : 64'd0);
        end
    end

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        pkt_idx_d  = pkt_idx_q;
        pass_d     = pass_q;
        sel_d      = sel_q;
        k_d        = k_q;
        a_d        = a_q;
        wrd_d      = wrd_q;
        core_num_d = core_num_q;
        o_core_dat = {NUM_CORES{i_dat}};
        o_core_sop = {NUM_CORES{i_sop}};
        o_core_eop = {NUM_CORES{i_eop}};
        o_core_val = '0;
        o_core_ctl = '0;
        o_rdy      = 1'b0;
        o_res_rdy  = '0;
        o_pnt_dat  = '0;
        o_pnt_val  = 1'b0;
        o_pnt_sop  = 1'b0;
        o_pnt_eop  = 1'b0;
        chkVld     = 1'b0;
        chkSop     = 1'b0;
        chkEop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    num_d      = i_num_in;
                    core_num_d = startCnt;
                    a_d        = (i_num_in >= 64'(NUM_CORES)) ? K_W'(NUM_CORES) : K_W'(i_num_in);
                    pkt_idx_d  = '0;
                    pass_d     = '0;
                    sel_d      = '0;
                    k_d        = '0;
                    wrd_d      = '0;
                    state_d    = (i_num_in == 64'd0) ? OUT_ZERO : DISPATCH;
                end
            end

            DISPATCH: begin
                o_core_val[sel_q] = i_val;
                o_rdy             = i_core_rdy[sel_q];
                if (i_val && i_core_rdy[sel_q] && i_eop) begin
                    if (pkt_idx_q == num_q - 64'd1) begin
                        pkt_idx_d = '0;
                        sel_d     = '0;
                        pass_d    = pass_q + 64'd1;
                        if (pass_q == 64'(KEY_BITS - 1)) begin
                            state_d = DRAIN0;
                        end
                    end else begin
                        pkt_idx_d = pkt_idx_q + 64'd1;
                        sel_d     = (sel_q == SEL_W'(NUM_CORES - 1)) ? '0 : sel_q + SEL_W'(1);
                    end
                end
            end

            // Core 0's own result stays inside the core as its accumulator seed.
            DRAIN0: begin
                o_res_rdy[0] = 1'b1;
                if (i_res_val[0] && i_res_eop[0]) begin
                    if (a_q == K_W'(1)) begin
                        state_d = OUT_PASS;
                    end else begin
                        k_d     = SEL_W'(1);
                        state_d = FWD;
                    end
                end
            end

            FWD: begin
                o_core_val[0]           = resValK;
                o_core_dat[DAT_BITS-1:0] = resDatK;
                o_core_sop[0]           = resSopK;
                o_core_eop[0]           = resEopK;
                o_core_ctl[0]           = 1'b1;
                o_res_rdy[k_q]          = i_core_rdy[0];
                if (resValK && i_core_rdy[0]) begin
                    chkVld = 1'b1;
                    chkSop = resSopK;
                    chkEop = resEopK;
                    wrd_d  = resEopK ? '0 : wrd_q + CNT_W'(1);
                    if (resEopK) begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!kLast) begin
                    o_res_rdy[0] = 1'b1;
                    if (i_res_val[0] && i_res_eop[0]) begin
                        k_d     = k_q + SEL_W'(1);
                        state_d = FWD;
                    end
                end
            end

            OUT_ZERO: begin
                o_pnt_val = 1'b1;
                o_pnt_sop = (wrd_q == '0);
                o_pnt_eop = (wrd_q == CNT_W'(NUM_WRDS - 1));
                if (i_pnt_rdy) begin
                    wrd_d = o_pnt_eop ? '0 : wrd_q + CNT_W'(1);
                    if (o_pnt_eop) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
            end
        endcase

        // Final partial sum from core 0 flows straight to the output port.
        if (passThru) begin
            o_pnt_dat    = i_res_dat[DAT_BITS-1:0];
            o_pnt_val    = i_res_val[0];
            o_pnt_sop    = i_res_sop[0];
            o_pnt_eop    = i_res_eop[0];
            o_res_rdy[0] = i_pnt_rdy;
            if (i_res_val[0] && i_pnt_rdy) begin
                chkVld = 1'b1;
                chkSop = i_res_sop[0];
                chkEop = i_res_eop[0];
                wrd_d  = i_res_eop[0] ? '0 : wrd_q + CNT_W'(1);
                if (i_res_eop[0]) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            num_q      <= '0;
            pkt_idx_q  <= '0;
            pass_q     <= '0;
            sel_q      <= '0;
            k_q        <= '0;
            a_q        <= '0;
            wrd_q      <= '0;
            core_num_q <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            pkt_idx_q  <= pkt_idx_d;
            pass_q     <= pass_d;
            sel_q      <= sel_d;
            k_q        <= k_d;
            a_q        <= a_d;
            wrd_q      <= wrd_d;
            core_num_q <= core_num_d;
        end
    end

    // Framing comes from the cores; an independent word count flags malformed packets.
    assert property (@(posedge i_clk) disable iff (i_rst)
        chkVld |-> ((chkSop == (wrd_q == '0)) && (chkEop == (wrd_q == CNT_W'(NUM_WRDS - 1)))));

endmodule

// File: tb/tb_multiexp_dispatch.sv
// Scoreboard bench for multiexp_dispatch: table of jobs with expected per-core counts,
// fake core result streams, random stalls, mid-job reset and start/finish collision.
module tb_multiexp_dispatch;

    localparam int NC  = 4;
    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int NW  = 6;
    localparam int KB  = 2;
    localparam int TMO = 400;

    logic               i_clk;
    logic               i_rst;
    logic               i_start;
    logic [63:0]        i_num_in;
    logic               o_busy;
    logic [DW-1:0]      i_dat;
    logic               i_val, i_sop, i_eop;
    logic               o_rdy;
    logic [NC*DW-1:0]   o_core_dat;
    logic [NC-1:0]      o_core_val, o_core_sop, o_core_eop;
    logic [NC*CW-1:0]   o_core_ctl;
    logic [NC-1:0]      i_core_rdy;
    logic [NC*64-1:0]   o_core_num_in;
    logic [NC*DW-1:0]   i_res_dat;
    logic [NC-1:0]      i_res_val, i_res_sop, i_res_eop;
    logic [NC-1:0]      o_res_rdy;
    logic [DW-1:0]      o_pnt_dat;
    logic               o_pnt_val, o_pnt_sop, o_pnt_eop;
    logic               i_pnt_rdy;

    multiexp_dispatch #(
        .NUM_CORES(NC), .DAT_BITS(DW), .CTL_BITS(CW), .NUM_WRDS(NW), .KEY_BITS(KB)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_in(i_num_in), .o_busy(o_busy),
        .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .o_rdy(o_rdy),
        .o_core_dat(o_core_dat), .o_core_val(o_core_val), .o_core_sop(o_core_sop),
        .o_core_eop(o_core_eop), .o_core_ctl(o_core_ctl), .i_core_rdy(i_core_rdy),
        .o_core_num_in(o_core_num_in), .i_res_dat(i_res_dat), .i_res_val(i_res_val),
        .i_res_sop(i_res_sop), .i_res_eop(i_res_eop), .o_res_rdy(o_res_rdy),
        .o_pnt_dat(o_pnt_dat), .o_pnt_val(o_pnt_val), .o_pnt_sop(o_pnt_sop),
        .o_pnt_eop(o_pnt_eop), .i_pnt_rdy(i_pnt_rdy)
    );

    typedef struct {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
        int            core;
        logic [CW-1:0] ctl;
    } coreExp_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
    } pntExp_t;

    typedef struct {
        logic [63:0]      num;
        logic [NC*64-1:0] expNum;
        bit               stall;
        bit               startAtEnd;
    } vec_t;

    coreExp_t      coreQ[$];
    pntExp_t       pntQ[$];
    vec_t          vecs[9];
    int            checks = 0;
    int            errors = 0;
    bit            stallEn = 0;
    bit            monEn = 0;
    logic [NC-1:0] coreRdyMask = '1;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Ready generator: fully ready, masked, or 50% random stalls.
    initial begin
        i_core_rdy = '1;
        i_pnt_rdy  = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            if (stallEn) begin
                i_core_rdy = NC'($urandom);
                i_pnt_rdy  = 1'($urandom);
            end else begin
                i_core_rdy = coreRdyMask;
                i_pnt_rdy  = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic checkOutput(input string name, input logic [NC*64-1:0] act, input logic [NC*64-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string what);
        checks++;
        errors++;
        $display("[TB] FAIL timeout %s: no handshake within %0d cycles", what, TMO);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Core-input and final-point monitors, sampled on the falling edge.
    initial begin
        coreExp_t ce;
        pntExp_t  pe;
        forever begin
            @(negedge i_clk);
            if (monEn) begin
                for (int c = 0; c < NC; c++) begin
                    if (o_core_val[c]) begin
                        if (coreQ.size() == 0 || coreQ[0].core != c) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL core val: core %0d valid with data %0h, required idle", c, o_core_dat[c*DW +: DW]);
                        end else if (i_core_rdy[c]) begin
                            ce = coreQ.pop_front();
                            checkOutput("core dat", (NC*64)'(o_core_dat[c*DW +: DW]), (NC*64)'(ce.dat));
                            checkOutput("core sop/eop", (NC*64)'({o_core_sop[c], o_core_eop[c]}), (NC*64)'({ce.sop, ce.eop}));
                            checkOutput("core ctl", (NC*64)'(o_core_ctl[c*CW +: CW]), (NC*64)'(ce.ctl));
                        end
                    end
                end
                if (o_pnt_val) begin
                    if (pntQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL pnt val: valid with data %0h, required idle", o_pnt_dat);
                    end else if (i_pnt_rdy) begin
                        pe = pntQ.pop_front();
                        checkOutput("pnt dat", (NC*64)'(o_pnt_dat), (NC*64)'(pe.dat));
                        checkOutput("pnt sop/eop", (NC*64)'({o_pnt_sop, o_pnt_eop}), (NC*64)'({pe.sop, pe.eop}));
                    end
                end
            end
        end
    end

    task automatic waitCycle();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one word on the main input stream and hold it until accepted.
    task automatic applyStimulus(input logic [DW-1:0] dat, input logic sop, input logic eop);
        int n;
        i_dat = dat;
        i_sop = sop;
        i_eop = eop;
        i_val = 1'b1;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_rdy) break;
            n++;
            if (n > TMO) failTimeout("input stream");
        end
        waitCycle();
        i_val = 1'b0;
    endtask

    // Play one fake core result packet on result port c.
    task automatic driveRes(input int c, input logic [DW-1:0] base, input bit startLast);
        int n;
        for (int w = 0; w < NW; w++) begin
            i_res_dat[c*DW +: DW] = base | DW'(w);
            i_res_sop[c] = (w == 0);
            i_res_eop[c] = (w == NW - 1);
            i_res_val[c] = 1'b1;
            if (startLast && w == NW - 1) begin
                i_num_in = 64'd99;
                i_start  = 1'b1;
            end
            n = 0;
            forever begin
                @(negedge i_clk);
                if (o_res_rdy[c]) break;
                n++;
                if (n > TMO) failTimeout("result stream");
            end
            waitCycle();
            i_res_val[c] = 1'b0;
        end
        i_start = 1'b0;
    endtask

    task automatic runJob(input vec_t v, input int jobId);
        int            n;
        int            numA;
        logic [DW-1:0] base;
        stallEn = v.stall;
        if (v.num == 64'd0) begin
            for (int w = 0; w < NW; w++) pntQ.push_back('{dat: '0, sop: (w == 0), eop: (w == NW - 1)});
        end
        i_num_in = v.num;
        i_start  = 1'b1;
        waitCycle();
        i_start  = 1'b0;
        @(negedge i_clk);
        checkOutput("core num_in", o_core_num_in, v.expNum);
        checkOutput("busy after start", (NC*64)'(o_busy), (NC*64)'(1));
        waitCycle();
        if (v.num != 64'd0) begin
            for (int pass = 0; pass < KB; pass++) begin
                for (int p = 0; p < int'(v.num); p++) begin
                    for (int w = 0; w <= NW; w++) begin
                        base = {8'(jobId), 4'(pass), 12'(p), 8'(w)};
                        coreQ.push_back('{dat: base, sop: (w == 0), eop: (w == NW), core: p % NC, ctl: '0});
                        applyStimulus(base, (w == 0), (w == NW));
                    end
                end
            end
            numA = (int'(v.num) < NC) ? int'(v.num) : NC;
            driveRes(0, {8'hD0, 8'(jobId), 16'h0000}, 1'b0);
            for (int k = 1; k < numA; k++) begin
                base = {8'hA0, 8'(jobId), 8'(k), 8'h00};
                for (int w = 0; w < NW; w++) begin
                    coreQ.push_back('{dat: base | DW'(w), sop: (w == 0), eop: (w == NW - 1), core: 0, ctl: CW'(1)});
                end
                driveRes(k, base, 1'b0);
                base = {8'hE0, 8'(jobId), 8'(k), 8'h00};
                if (k == numA - 1) begin
                    for (int w = 0; w < NW; w++) pntQ.push_back('{dat: base | DW'(w), sop: (w == 0), eop: (w == NW - 1)});
                end
                driveRes(0, base, (k == numA - 1) && v.startAtEnd);
            end
            if (numA == 1) begin
                base = {8'hE0, 8'(jobId), 16'h0000};
                for (int w = 0; w < NW; w++) pntQ.push_back('{dat: base | DW'(w), sop: (w == 0), eop: (w == NW - 1)});
                driveRes(0, base, v.startAtEnd);
            end
        end
        n = 0;
        forever begin
            @(negedge i_clk);
            if (!o_busy) break;
            n++;
            if (n > TMO) failTimeout("job completion");
        end
        checkOutput("busy cleared", (NC*64)'(o_busy), '0);
        checkOutput("scoreboard empty", (NC*64)'(coreQ.size() + pntQ.size()), '0);
        if (v.startAtEnd) checkOutput("num_in kept after ignored start", o_core_num_in, v.expNum);
        waitCycle();
        stallEn = 0;
    endtask

    function automatic vec_t mkVec(input int n, input int c0, input int c1, input int c2, input int c3,
                                   input bit st, input bit se);
        vec_t v;
        v.num        = 64'(n);
        v.expNum     = {64'(c3), 64'(c2), 64'(c1), 64'(c0)};
        v.stall      = st;
        v.startAtEnd = se;
        return v;
    endfunction

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_num_in = '0;
        i_dat = '0; i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        i_res_dat = '0; i_res_val = '0; i_res_sop = '0; i_res_eop = '0;

        vecs[0] = mkVec(8, 2, 2, 2, 2, 0, 0);
        vecs[1] = mkVec(6, 2, 2, 1, 1, 0, 0);
        vecs[2] = mkVec(2, 1, 1, 0, 0, 0, 0);
        vecs[3] = mkVec(0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mkVec(5, 2, 1, 1, 1, 0, 0);
        vecs[5] = mkVec(1, 1, 0, 0, 0, 0, 1);
        vecs[6] = mkVec(6, 2, 2, 1, 1, 1, 0);
        vecs[7] = mkVec(8, 2, 2, 2, 2, 1, 1);
        vecs[8] = mkVec(0, 0, 0, 0, 0, 1, 0);

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("reset busy", (NC*64)'(o_busy), '0);
        checkOutput("reset rdy", (NC*64)'(o_rdy), '0);
        checkOutput("reset core val", (NC*64)'(o_core_val), '0);
        checkOutput("reset res rdy", (NC*64)'(o_res_rdy), '0);
        checkOutput("reset pnt val", (NC*64)'(o_pnt_val), '0);
        checkOutput("reset num_in", o_core_num_in, '0);
        waitCycle();
        monEn = 1;

        for (int i = 0; i < 9; i++) begin
            $display("[TB] job %0d: N=%0d stall=%0d", i + 1, vecs[i].num, vecs[i].stall);
            runJob(vecs[i], i + 1);
        end

        // Mid-dispatch reset: one packet in, next word stalled, then reset with i_val still high.
        $display("[TB] reset during dispatch");
        i_num_in = 64'd8;
        i_start  = 1'b1;
        waitCycle();
        i_start  = 1'b0;
        for (int w = 0; w <= NW; w++) begin
            coreQ.push_back('{dat: {8'h77, 16'h0, 8'(w)}, sop: (w == 0), eop: (w == NW), core: 0, ctl: '0});
            applyStimulus({8'h77, 16'h0, 8'(w)}, (w == 0), (w == NW));
        end
        monEn       = 0;
        coreRdyMask = '0;
        i_core_rdy  = '0;
        i_dat = 32'h7700_0100; i_sop = 1'b1; i_eop = 1'b0; i_val = 1'b1;
        i_rst = 1'b1;
        waitCycle();
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("abort core val", (NC*64)'(o_core_val), '0);
        checkOutput("abort rdy", (NC*64)'(o_rdy), '0);
        checkOutput("abort busy", (NC*64)'(o_busy), '0);
        checkOutput("abort num_in", o_core_num_in, '0);
        checkOutput("abort queue", (NC*64)'(coreQ.size()), '0);
        i_val       = 1'b0;
        coreRdyMask = '1;
        coreQ.delete();
        waitCycle();
        monEn = 1;
        runJob(mkVec(3, 1, 1, 1, 0, 0, 0), 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
